tlm_window_mmio: RTL and testbench
==================================

Name: tlm_window_mmio

Overview:
- Memory-mapped telemetry window peripheral downstream of the core's telemetry counters (tlm_mcycle/tlm_minstret/tlm_stall).
- Sits behind the data-port mux as an MMIO target.
- Software writes START/STOP; the block latches counter values at each edge and computes modulo-2^32 deltas.
- Deltas are queued in a small snapshot FIFO that software pops via register reads, so benchmark loops no longer store raw counters to TCM.

Parameters:
- BASE_ADDR, 32'h9000_0000, byte base of the 64-byte register window.
- FIFO_DEPTH, 4, snapshot entries; power of two, 2..16.
- CNT_W, 32, counter and delta width.

Ports:
- clk  in  1  core clock
- rst_cpu  in  1  asynchronous active-low reset
- tlm_mcycle_i  in  CNT_W  live cycle counter
- tlm_minstret_i  in  CNT_W  live retired-instruction counter
- tlm_stall_i  in  CNT_W  live stall counter
- mem_addr_i  in  32  request byte address
- mem_data_wr_i  in  32  write data
- mem_rd_i  in  1  read request
- mem_wr_i  in  4  byte write strobes; nonzero means write
- mem_accept_o  out  1  request accepted this cycle
- mem_ack_o  out  1  response valid
- mem_data_rd_o  out  32  read data, valid with ack
- mem_error_o  out  1  error response, valid with ack
- irq_o  out  1  snapshot-available interrupt (optional feature)

Behaviour:
- Reset (rst_cpu low, async): state IDLE, FIFO empty, start latches 0, overflow 0. Outputs mem_ack_o=0, mem_data_rd_o=0, mem_error_o=0, irq_o=0, mem_accept_o=1.
- Handshake:
  - mem_accept_o = !ack_pending.
  - A request is a cycle with accept and (rd or wr!=0).
  - mem_ack_o pulses exactly 1 cycle later with registered data/error.
  - Back-to-back requests allowed: accept falls only in the ack cycle, so one request every 2 cycles max.
- Decode: offset = mem_addr_i - BASE_ADDR. Address outside [BASE, BASE+0x40), unmapped offset, or write to read-only register: ack with error=1, data 0, no side effects. Writes use full word (strobes ignored beyond nonzero).
- Register map:
  - 0x00 CTRL (W): b0 START, b1 STOP, b2 FLUSH, b3 IE. Reads return {IE,3'b0}.
  - 0x04 STATUS (R): b0 running; b[7:4] fill count; b8 overflow sticky; b9 empty. Overflow is cleared by FLUSH.
  - 0x08 POP_CYC (R): returns head cycle delta, pops the entry, copies its inst/stall deltas to holding regs.
  - 0x0C HOLD_INST (R), 0x10 HOLD_STALL (R): holding regs.
  - 0x14 LIVE_CYC (R): tlm_mcycle_i sampled at request.
- FSM IDLE/RUN:
  - IDLE + START: latch all three counters, go to RUN.
  - RUN + START: relatch, stay in RUN.
  - RUN + STOP: delta = live - start (CNT_W wrap, unsigned), push {cyc,inst,stall}, go to IDLE.
  - IDLE + STOP: ignored.
  - START+STOP in one write: STOP takes priority if in RUN, otherwise START.
  - FLUSH: empties FIFO and clears overflow; combined with STOP, the flush applies after the push.
- FIFO:
  - Push when full: entry dropped, overflow set.
  - Pop when empty: data 0, holding regs unchanged, no error.
  - Pop and push in the same cycle while full: both succeed, no overflow.
- Counter wrap between START and STOP: a single wrap yields the correct modular delta.

Optional Feature:
- TLM_WINDOW_IRQ_EN defined: irq_o registered = IE & !empty; falls the cycle after the pop that empties the FIFO.
- Undefined: irq_o tied 0; IE bit writes are ignored and read 0.

Decomposition:
- Package tlm_window_pkg:
  - register offset localparams
  - CTRL/STATUS bit-position constants
  - typedef struct packed tlm_snap_t {cyc, inst, stall}
  - typedef enum {IDLE, RUN} tlm_state_e
- Sub-module tlm_snap_fifo: synchronous FIFO of tlm_snap_t with push/pop/flush, full/empty/count, same-cycle push+pop when full.

Test Plan:
- Write START with mcycle=100, minstret=40, stall=5; write STOP at 350/190/25 -> POP_CYC=250, HOLD_INST=150, HOLD_STALL=20, STATUS.empty=1 afterwards.
- START at mcycle=32'hFFFF_FFF0, STOP at 32'h0000_0010 -> POP_CYC=32'h20.
- Five START/STOP pairs without pops (DEPTH 4) -> count=4, overflow=1; pops return first four deltas in order; FLUSH clears overflow.
- Read BASE+0x3C and write STATUS -> ack one cycle later with error=1, no state change; read BASE+0x40 -> error=1.
- Pop with FIFO empty -> data 0, error 0; reset asserted mid-RUN -> STATUS reads 0x200 (empty only), ack low.
- With TLM_WINDOW_IRQ_EN and IE=1: STOP push -> irq_o=1 next cycle; pop the only entry -> irq_o=0 the following cycle.

Source files
------------

// File: rtl/tlm_window_pkg.sv
// Shared definitions for the telemetry window MMIO peripheral:
// register offsets, CTRL/STATUS bit positions, snapshot record and FSM states.
package tlm_window_pkg;

   localparam int unsigned TLM_CNT_W = 32;

   localparam logic [5:0] OFF_CTRL       = 6'h00;
   localparam logic [5:0] OFF_STATUS     = 6'h04;
   localparam logic [5:0] OFF_POP_CYC    = 6'h08;
   localparam logic [5:0] OFF_HOLD_INST  = 6'h0C;
   localparam logic [5:0] OFF_HOLD_STALL = 6'h10;
   localparam logic [5:0] OFF_LIVE_CYC   = 6'h14;

   localparam logic [31:0] WIN_BYTES = 32'h40;

   localparam int unsigned CTRL_START = 0;
   localparam int unsigned CTRL_STOP  = 1;
   localparam int unsigned CTRL_FLUSH = 2;
   localparam int unsigned CTRL_IE    = 3;

   localparam int unsigned ST_RUNNING   = 0;
   localparam int unsigned ST_COUNT_LSB = 4;
   localparam int unsigned ST_OVERFLOW  = 8;
   localparam int unsigned ST_EMPTY     = 9;

   typedef struct packed {
      logic [TLM_CNT_W-1:0] cyc;
      logic [TLM_CNT_W-1:0] inst;
      logic [TLM_CNT_W-1:0] stall;
   } tlm_snap_t;

   typedef enum logic {IDLE, RUN} tlm_state_e;

endpackage

// File: rtl/tlm_snap_fifo.sv
// Synchronous snapshot FIFO with flush; a push into a full FIFO succeeds
// when a pop happens in the same cycle.
module tlm_snap_fifo
   import tlm_window_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)
(
   input  logic                   clk,
   input  logic                   rst_cpu,
   input  logic                   push,
   input  tlm_snap_t              push_data,
   input  logic                   pop,
   input  logic                   flush,
   output tlm_snap_t              head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);

   tlm_snap_t      mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   // Pointer update; flush overrides any push or pop in the same cycle.
   always_ff @(posedge clk or negedge rst_cpu) begin
      if (!rst_cpu) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write; contents need no reset since empty masks the head.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/tlm_window_mmio.sv
// Telemetry window MMIO target: START/STOP latch the core counters, STOP
// pushes modulo-2^CNT_W deltas into a snapshot FIFO popped via register reads.
// Optional feature macro: TLM_WINDOW_IRQ_EN (snapshot-available interrupt).
module tlm_window_mmio
   import tlm_window_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 32
)
(
   input  logic             clk,
   input  logic             rst_cpu,
   input  logic [CNT_W-1:0] tlm_mcycle_i,
   input  logic [CNT_W-1:0] tlm_minstret_i,
   input  logic [CNT_W-1:0] tlm_stall_i,
   input  logic [31:0]      mem_addr_i,
   input  logic [31:0]      mem_data_wr_i,
   input  logic             mem_rd_i,
   input  logic [3:0]       mem_wr_i,
   output logic             mem_accept_o,
   output logic             mem_ack_o,
   output logic [31:0]      mem_data_rd_o,
   output logic             mem_error_o,
   output logic             irq_o
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   tlm_state_e       state_q, state_d;
   logic             ack_q, err_q;
   logic [31:0]      rdata_q;
   logic [CNT_W-1:0] start_cyc_q, start_inst_q, start_stall_q;
   logic [31:0]      hold_inst_q, hold_stall_q;
   logic             overflow_q;
   logic             ie_q;

   logic [31:0]      offset;
   logic [5:0]       off6;
   logic             is_wr, req, in_win, mapped, read_only, req_err, acc_ok;
   logic             ctrl_wr, pop_rd, flush, latch_en, push_en;
   logic [31:0]      rd_mux;

   tlm_snap_t        push_data, fifo_head;
   logic             fifo_full, fifo_empty;
   logic [CW-1:0]    fifo_count;

   assign mem_accept_o  = ~ack_q;
   assign mem_ack_o     = ack_q;
   assign mem_error_o   = err_q;
   assign mem_data_rd_o = rdata_q;

   assign is_wr   = |mem_wr_i;
   assign req     = mem_accept_o & (mem_rd_i | is_wr);
   assign offset  = mem_addr_i - BASE_ADDR;
   assign in_win  = (offset < WIN_BYTES);
   assign off6    = offset[5:0];
   assign req_err = ~in_win | ~mapped | (is_wr & read_only);
   assign acc_ok  = req & ~req_err;
   assign ctrl_wr = acc_ok & is_wr & (off6 == OFF_CTRL);
   assign pop_rd  = acc_ok & ~is_wr & (off6 == OFF_POP_CYC);
   assign flush   = ctrl_wr & mem_data_wr_i[CTRL_FLUSH];

   assign push_data.cyc   = TLM_CNT_W'(tlm_mcycle_i   - start_cyc_q);
   assign push_data.inst  = TLM_CNT_W'(tlm_minstret_i - start_inst_q);
   assign push_data.stall = TLM_CNT_W'(tlm_stall_i    - start_stall_q);

   logic unused_ok;
   assign unused_ok = &{1'b0, mem_data_wr_i, fifo_count};

   // Register map decode: which offsets exist and which reject writes.
   always_comb begin
      mapped    = 1'b1;
      read_only = 1'b1;
      case (off6)
         OFF_CTRL:       read_only = 1'b0;
         OFF_STATUS, OFF_POP_CYC, OFF_HOLD_INST,
         OFF_HOLD_STALL, OFF_LIVE_CYC: ;
         default:        mapped = 1'b0;
      endcase
   end

   // Read data mux; an empty pop returns zero.
   always_comb begin
      rd_mux = '0;
      case (off6)
         OFF_CTRL:       rd_mux[CTRL_IE] = ie_q;
         OFF_STATUS: begin
            rd_mux[ST_RUNNING]          = (state_q == RUN);
            rd_mux[ST_COUNT_LSB +: 4]   = 4'(fifo_count);
            rd_mux[ST_OVERFLOW]         = overflow_q;
            rd_mux[ST_EMPTY]            = fifo_empty;
         end
         OFF_POP_CYC:    rd_mux = fifo_empty ? '0 : 32'(fifo_head.cyc);
         OFF_HOLD_INST:  rd_mux = hold_inst_q;
         OFF_HOLD_STALL: rd_mux = hold_stall_q;
         OFF_LIVE_CYC:   rd_mux = 32'(tlm_mcycle_i);
         default: ;
      endcase
   end

   // Window FSM next state: STOP wins over START while running.
   always_comb begin
      state_d  = state_q;
      latch_en = 1'b0;
      push_en  = 1'b0;
      if (ctrl_wr) begin
         case (state_q)
            IDLE: if (mem_data_wr_i[CTRL_START]) begin
               latch_en = 1'b1;
               state_d  = RUN;
            end
            RUN: if (mem_data_wr_i[CTRL_STOP]) begin
               push_en = 1'b1;
               state_d = IDLE;
            end else if (mem_data_wr_i[CTRL_START]) begin
               latch_en = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_cpu) begin
      if (!rst_cpu) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Response register: one-cycle ack with data or error.
   always_ff @(posedge clk or negedge rst_cpu) begin
      if (!rst_cpu) begin
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= req;
         err_q   <= req & req_err;
         rdata_q <= (req & ~req_err & ~is_wr) ? rd_mux : '0;
      end
   end

   // Start latches, holding registers and sticky overflow.
   always_ff @(posedge clk or negedge rst_cpu) begin
      if (!rst_cpu) begin
         start_cyc_q   <= '0;
         start_inst_q  <= '0;
         start_stall_q <= '0;
         hold_inst_q   <= '0;
         hold_stall_q  <= '0;
         overflow_q    <= 1'b0;
      end else begin
         if (latch_en) begin
            start_cyc_q   <= tlm_mcycle_i;
            start_inst_q  <= tlm_minstret_i;
            start_stall_q <= tlm_stall_i;
         end
         if (pop_rd && !fifo_empty) begin
            hold_inst_q  <= 32'(fifo_head.inst);
            hold_stall_q <= 32'(fifo_head.stall);
         end
         // Flush applies after a same-write push, so it also clears a fresh overflow.
         if (flush)
            overflow_q <= 1'b0;
         else if (push_en && fifo_full && !pop_rd)
            overflow_q <= 1'b1;
      end
   end

`ifdef TLM_WINDOW_IRQ_EN
   logic irq_q;
   assign irq_o = irq_q;

   // Interrupt enable and registered snapshot-available interrupt.
   always_ff @(posedge clk or negedge rst_cpu) begin
      if (!rst_cpu) begin
         ie_q  <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (ctrl_wr) ie_q <= mem_data_wr_i[CTRL_IE];
         irq_q <= ie_q & ~fifo_empty;
      end
   end
`else
   assign ie_q  = 1'b0;
   assign irq_o = 1'b0;
`endif

   tlm_snap_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_cpu   (rst_cpu),
      .push      (push_en),
      .push_data (push_data),
      .pop       (pop_rd),
      .flush     (flush),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_tlm_window_mmio.sv
// Directed self-checking bench for tlm_window_mmio with hand-computed expectations.
module tb_tlm_window_mmio;

   localparam logic [31:0] BASE = 32'h9000_0000;

   logic        clk = 1'b0;
   logic        rst_cpu = 1'b0;
   logic [31:0] tlm_mcycle_i = '0;
   logic [31:0] tlm_minstret_i = '0;
   logic [31:0] tlm_stall_i = '0;
   logic [31:0] mem_addr_i = '0;
   logic [31:0] mem_data_wr_i = '0;
   logic        mem_rd_i = 1'b0;
   logic [3:0]  mem_wr_i = '0;
   logic        mem_accept_o, mem_ack_o, mem_error_o, irq_o;
   logic [31:0] mem_data_rd_o;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   tlm_window_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .CNT_W(32)) dut (
      .clk            (clk),
      .rst_cpu        (rst_cpu),
      .tlm_mcycle_i   (tlm_mcycle_i),
      .tlm_minstret_i (tlm_minstret_i),
      .tlm_stall_i    (tlm_stall_i),
      .mem_addr_i     (mem_addr_i),
      .mem_data_wr_i  (mem_data_wr_i),
      .mem_rd_i       (mem_rd_i),
      .mem_wr_i       (mem_wr_i),
      .mem_accept_o   (mem_accept_o),
      .mem_ack_o      (mem_ack_o),
      .mem_data_rd_o  (mem_data_rd_o),
      .mem_error_o    (mem_error_o),
      .irq_o          (irq_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One request; returns the acked data and error, checking the ack timing.
   task automatic xfer(input logic [31:0] addr, input logic [3:0] wr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
      @(negedge clk);
      mem_addr_i    = addr;
      mem_wr_i      = wr;
      mem_rd_i      = (wr == 4'h0);
      mem_data_wr_i = wdata;
      @(negedge clk);
      mem_rd_i = 1'b0;
      mem_wr_i = 4'h0;
      check("ack", 32'(mem_ack_o), 32'd1);
      check("accept_low_in_ack", 32'(mem_accept_o), 32'd0);
      rdata = mem_data_rd_o;
      err   = mem_error_o;
   endtask

   task automatic rd_chk(input string tag, input logic [5:0] off, input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      xfer(BASE + 32'(off), 4'h0, 32'h0, d, e);
      check(tag, d, exp);
      check({tag, "_err"}, 32'(e), 32'd0);
   endtask

   task automatic wr_ctrl(input logic [31:0] val);
      logic [31:0] d;
      logic        e;
      xfer(BASE, 4'h1, val, d, e);
      check("ctrl_wr_err", 32'(e), 32'd0);
   endtask

   task automatic err_chk(input string tag, input logic [31:0] addr, input logic [3:0] wr,
                          input logic [31:0] wdata);
      logic [31:0] d;
      logic        e;
      xfer(addr, wr, wdata, d, e);
      check({tag, "_err"}, 32'(e), 32'd1);
      check({tag, "_data"}, d, 32'h0);
   endtask

   task automatic set_cnt(input logic [31:0] c, input logic [31:0] i, input logic [31:0] s);
      tlm_mcycle_i   = c;
      tlm_minstret_i = i;
      tlm_stall_i    = s;
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_ack", 32'(mem_ack_o), 32'd0);
      check("rst_data", mem_data_rd_o, 32'h0);
      check("rst_err", 32'(mem_error_o), 32'd0);
      check("rst_irq", 32'(irq_o), 32'd0);
      check("rst_accept", 32'(mem_accept_o), 32'd1);
      @(negedge clk);
      rst_cpu = 1'b1;
      rd_chk("status_reset", 6'h04, 32'h200);

      // Basic window
      set_cnt(100, 40, 5);
      wr_ctrl(32'h1);
      rd_chk("status_run", 6'h04, 32'h201);
      set_cnt(350, 190, 25);
      wr_ctrl(32'h2);
      rd_chk("status_one", 6'h04, 32'h010);
`ifndef TLM_WINDOW_IRQ_EN
      check("irq_tied", 32'(irq_o), 32'd0);
`endif
      rd_chk("pop_cyc", 6'h08, 32'd250);
      rd_chk("hold_inst", 6'h0C, 32'd150);
      rd_chk("hold_stall", 6'h10, 32'd20);
      rd_chk("status_empty", 6'h04, 32'h200);

      // Counter wrap
      set_cnt(32'hFFFF_FFF0, 0, 0);
      wr_ctrl(32'h1);
      set_cnt(32'h0000_0010, 0, 0);
      wr_ctrl(32'h2);
      rd_chk("pop_wrap", 6'h08, 32'h20);

      // Overflow: five windows into a depth-4 FIFO
      for (int i = 0; i < 5; i++) begin
         set_cnt(1000, 0, 0);
         wr_ctrl(32'h1);
         set_cnt(1000 + 10 * (i + 1), i + 1, 0);
         wr_ctrl(32'h2);
      end
      rd_chk("status_full_ovf", 6'h04, 32'h140);
      for (int i = 0; i < 4; i++) begin
         rd_chk("pop_ovf", 6'h08, 32'(10 * (i + 1)));
         rd_chk("hold_inst_ovf", 6'h0C, 32'(i + 1));
      end
      rd_chk("status_ovf_empty", 6'h04, 32'h300);
      wr_ctrl(32'h4);
      rd_chk("status_flushed", 6'h04, 32'h200);

      // Decode errors with no side effects
      err_chk("rd_3c", BASE + 32'h3C, 4'h0, 32'h0);
      err_chk("wr_status", BASE + 32'h04, 4'hF, 32'hFFFF_FFFF);
      err_chk("rd_40", BASE + 32'h40, 4'h0, 32'h0);
      err_chk("rd_below", BASE - 32'h4, 4'h0, 32'h0);
      err_chk("wr_40_start", BASE + 32'h40, 4'hF, 32'h1);
      err_chk("wr_unaligned", BASE + 32'h01, 4'h1, 32'h1);
      rd_chk("status_after_err", 6'h04, 32'h200);

      // Empty pop
      rd_chk("pop_empty", 6'h08, 32'h0);
      rd_chk("hold_inst_kept", 6'h0C, 32'd4);

      // Live counter and CTRL readback
      set_cnt(32'h1234_5678, 0, 0);
      rd_chk("live_cyc", 6'h14, 32'h1234_5678);
      wr_ctrl(32'h8);
`ifdef TLM_WINDOW_IRQ_EN
      rd_chk("ctrl_ie", 6'h00, 32'h8);
`else
      rd_chk("ctrl_ie", 6'h00, 32'h0);
`endif
      wr_ctrl(32'h0);

      // START+STOP priority, relatch, STOP+FLUSH
      set_cnt(500, 0, 0);
      wr_ctrl(32'h3);
      rd_chk("ss_idle_starts", 6'h04, 32'h201);
      wr_ctrl(32'h3);
      rd_chk("ss_run_stops", 6'h04, 32'h010);
      set_cnt(100, 0, 0);
      wr_ctrl(32'h1);
      set_cnt(200, 0, 0);
      wr_ctrl(32'h1);
      set_cnt(260, 0, 0);
      wr_ctrl(32'h2);
      rd_chk("pop_ss", 6'h08, 32'd0);
      rd_chk("pop_relatch", 6'h08, 32'd60);
      wr_ctrl(32'h1);
      wr_ctrl(32'h6);
      rd_chk("stop_flush", 6'h04, 32'h200);

`ifdef TLM_WINDOW_IRQ_EN
      // Interrupt rises after a push and falls after the emptying pop
      set_cnt(10, 0, 0);
      wr_ctrl(32'h9);
      set_cnt(20, 0, 0);
      wr_ctrl(32'hA);
      @(posedge clk); #1;
      check("irq_set", 32'(irq_o), 32'd1);
      rd_chk("irq_pop", 6'h08, 32'd10);
      check("irq_hold", 32'(irq_o), 32'd1);
      @(posedge clk); #1;
      check("irq_clear", 32'(irq_o), 32'd0);
      wr_ctrl(32'h0);
`endif

      // Reset asserted mid-RUN
      wr_ctrl(32'h1);
      rd_chk("status_pre_rst", 6'h04, 32'h201);
      @(negedge clk);
      mem_addr_i = BASE + 32'h04;
      mem_rd_i   = 1'b1;
      @(posedge clk); #2;
      rst_cpu  = 1'b0;
      mem_rd_i = 1'b0;
      #1;
      check("midrst_ack", 32'(mem_ack_o), 32'd0);
      check("midrst_accept", 32'(mem_accept_o), 32'd1);
      repeat (2) @(negedge clk);
      rst_cpu = 1'b1;
      rd_chk("status_post_rst", 6'h04, 32'h200);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
